// File: rtl/counter_mode_ctrl.sv
// Mode controller and step scheduler for the LED counter: turns debounced button
// levels into step/direction/clear strobes for manual, auto and bounce counting.
module counter_mode_ctrl #(
    parameter int N          = 6,
    parameter int TICK_DIV   = 25_000_000,
    parameter int LONG_PRESS = 50_000_000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         step_btn,
    input  logic         mode_btn,
    input  logic [N-1:0] count,
    output logic         cnt_en,
    output logic         cnt_up,
    output logic         cnt_clear,
    output logic [1:0]   mode,
    output logic         paused
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(LONG_PRESS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_PRESS - 1);
    localparam logic [HW-1:0] HOLD_SAT   = HW'(LONG_PRESS);

    typedef enum logic [1:0] {
        MODE_MANUAL    = 2'b00,
        MODE_AUTO_UP   = 2'b01,
        MODE_AUTO_DOWN = 2'b10,
        MODE_BOUNCE    = 2'b11
    } mode_e;

    mode_e         r_mode;
    logic          r_paused;
    logic          r_dir;
    logic [PW-1:0] r_presc;
    logic [HW-1:0] r_hold;
    logic          r_armed;
    logic          r_step_prev;
    logic          r_mode_prev;
    logic          r_cnt_en;
    logic          r_cnt_up;
    logic          r_cnt_clear;

    mode_e         w_mode_nxt;
    logic          w_paused_nxt;
    logic          w_dir_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic          w_armed_nxt;
    logic          w_en_nxt;
    logic          w_up_nxt;
    logic          w_clear_nxt;

    logic w_mode_rise;
    logic w_step_rise;
    logic w_step_fall;
    logic w_long;
    logic w_short;
    logic w_auto;
    logic w_tick;

    assign w_mode_rise = mode_btn & ~r_mode_prev;
    assign w_step_rise = step_btn & ~r_step_prev;
    assign w_step_fall = ~step_btn & r_step_prev;
    assign w_long      = r_armed & step_btn & (r_hold == HOLD_LAST);
    assign w_short     = w_step_fall & r_armed;
    assign w_auto      = (r_mode != MODE_MANUAL);
    assign w_tick      = w_auto & ~r_paused & (r_presc == PRESC_LAST);

    // Next-state decode: press tracking runs independently, then one prioritised event.
    always_comb begin
        w_mode_nxt   = r_mode;
        w_paused_nxt = r_paused;
        w_dir_nxt    = r_dir;
        w_presc_nxt  = r_presc;
        w_hold_nxt   = r_hold;
        w_armed_nxt  = r_armed;
        w_en_nxt     = 1'b0;
        w_up_nxt     = r_cnt_up;
        w_clear_nxt  = 1'b0;

        if (w_step_rise) begin
            w_armed_nxt = 1'b1;
            w_hold_nxt  = {HW{1'b0}};
        end else if (r_armed && step_btn && (r_hold != HOLD_SAT)) begin
            w_hold_nxt = r_hold + HW'(1);
        end else begin
            w_hold_nxt = r_hold;
        end

        // A press consumed by a higher-priority event is still consumed.
        if (w_long || w_short) begin
            w_armed_nxt = 1'b0;
        end else begin
            w_armed_nxt = w_armed_nxt;
        end

        if (w_mode_rise) begin
            case (r_mode)
                MODE_MANUAL:    w_mode_nxt = MODE_AUTO_UP;
                MODE_AUTO_UP:   w_mode_nxt = MODE_AUTO_DOWN;
                MODE_AUTO_DOWN: w_mode_nxt = MODE_BOUNCE;
                MODE_BOUNCE:    w_mode_nxt = MODE_MANUAL;
                default:        w_mode_nxt = MODE_MANUAL;
            endcase
            w_paused_nxt = 1'b0;
            w_presc_nxt  = {PW{1'b0}};
            w_dir_nxt    = 1'b1;
        end else if (w_long) begin
            w_clear_nxt = 1'b1;
            w_presc_nxt = {PW{1'b0}};
        end else if (w_short) begin
            if (!w_auto) begin
                w_en_nxt    = 1'b1;
                w_up_nxt    = 1'b1;
                w_presc_nxt = {PW{1'b0}};
            end else if (r_paused) begin
                w_paused_nxt = 1'b0;
                w_presc_nxt  = {PW{1'b0}};
            end else begin
                w_paused_nxt = 1'b1;
            end
        end else if (w_tick) begin
            w_en_nxt    = 1'b1;
            w_presc_nxt = {PW{1'b0}};
            case (r_mode)
                MODE_AUTO_UP:   w_up_nxt = 1'b1;
                MODE_AUTO_DOWN: w_up_nxt = 1'b0;
                MODE_BOUNCE: begin
                    // Turn around at the ends; the flipped direction applies to this very step.
                    if (r_dir && (count == {N{1'b1}})) begin
                        w_up_nxt  = 1'b0;
                        w_dir_nxt = 1'b0;
                    end else if (!r_dir && (count == {N{1'b0}})) begin
                        w_up_nxt  = 1'b1;
                        w_dir_nxt = 1'b1;
                    end else begin
                        w_up_nxt = r_dir;
                    end
                end
                default:        w_up_nxt = 1'b1;
            endcase
        end else if (w_auto && !r_paused) begin
            w_presc_nxt = r_presc + PW'(1);
        end else if (!w_auto) begin
            w_presc_nxt = {PW{1'b0}};
        end else begin
            w_presc_nxt = r_presc;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode      <= MODE_MANUAL;
            r_paused    <= 1'b0;
            r_dir       <= 1'b1;
            r_presc     <= {PW{1'b0}};
            r_hold      <= {HW{1'b0}};
            r_armed     <= 1'b0;
            r_step_prev <= 1'b1;
            r_mode_prev <= 1'b1;
            r_cnt_en    <= 1'b0;
            r_cnt_up    <= 1'b1;
            r_cnt_clear <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_paused    <= w_paused_nxt;
            r_dir       <= w_dir_nxt;
            r_presc     <= w_presc_nxt;
            r_hold      <= w_hold_nxt;
            r_armed     <= w_armed_nxt;
            r_step_prev <= step_btn;
            r_mode_prev <= mode_btn;
            r_cnt_en    <= w_en_nxt;
            r_cnt_up    <= w_up_nxt;
            r_cnt_clear <= w_clear_nxt;
        end
    end

    assign cnt_en    = r_cnt_en;
    assign cnt_up    = r_cnt_up;
    assign cnt_clear = r_cnt_clear;
    assign mode      = r_mode;
    assign paused    = r_paused;

endmodule

// File: tb/tb_counter_mode_ctrl.sv
// Scoreboard bench for counter_mode_ctrl: a behavioural model predicts strobes and
// mode/paused per clock; a negedge monitor pops and compares what the DUT presents.
module tb_counter_mode_ctrl;
    localparam int N  = 3;
    localparam int TD = 4;
    localparam int LP = 8;
    localparam int CMAX = (1 << N) - 1;

    logic         clock = 1'b0;
    logic         reset, step_btn, mode_btn;
    logic [N-1:0] count;
    logic         cnt_en, cnt_up, cnt_clear, paused;
    logic [1:0]   mode;

    counter_mode_ctrl #(.N(N), .TICK_DIV(TD), .LONG_PRESS(LP)) dut (
        .clock(clock), .reset(reset), .step_btn(step_btn), .mode_btn(mode_btn),
        .count(count), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_clear(cnt_clear),
        .mode(mode), .paused(paused)
    );

    always #5 clock = ~clock;

    typedef struct { int tag; bit clr; bit up; } ev_t;
    typedef struct { int tag; int mode; bit paused; } st_t;
    ev_t ev_q[$];
    st_t st_q[$];
    int  edge_cnt = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  rand_count = 1'b0;

    // Reference model state, in terms of the user-visible behaviour.
    int  m_mode, m_since_press, m_clks_since_step, m_cnt;
    bit  m_paused, m_dir_up, m_armed, m_prev_s, m_prev_m;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic model_reset();
        m_mode = 0; m_paused = 1'b0; m_dir_up = 1'b1; m_armed = 1'b0;
        m_since_press = 0; m_clks_since_step = 0; m_cnt = 0;
        m_prev_s = 1'b1; m_prev_m = 1'b1;
    endtask

    // Predict what the DUT shows after the coming rising edge.
    task automatic model_step();
        bit mode_ev, press, release_ev, long_ev, short_ev, tick, is_auto, en, clr, up;
        ev_t e; st_t s;
        if (reset) begin
            while (ev_q.size() > 0 && ev_q[$].tag == edge_cnt) void'(ev_q.pop_back());
            if (st_q.size() > 0 && st_q[$].tag == edge_cnt) begin
                s = st_q.pop_back(); s.mode = 0; s.paused = 1'b0; st_q.push_back(s);
            end
            model_reset();
            s.tag = edge_cnt + 1; s.mode = 0; s.paused = 1'b0; st_q.push_back(s);
            return;
        end
        mode_ev    = mode_btn && !m_prev_m;
        press      = step_btn && !m_prev_s;
        release_ev = !step_btn && m_prev_s;
        m_prev_m = mode_btn; m_prev_s = step_btn;
        if (press) begin m_armed = 1'b1; m_since_press = 0; end
        else if (m_armed && step_btn) m_since_press++;
        long_ev  = m_armed && step_btn && (m_since_press == LP);
        short_ev = release_ev && m_armed;
        if (long_ev || short_ev) m_armed = 1'b0;
        is_auto = (m_mode != 0);
        tick = is_auto && !m_paused && (m_clks_since_step == TD - 1);
        en = 1'b0; clr = 1'b0; up = 1'b1;
        if (mode_ev) begin
            m_mode = (m_mode + 1) % 4; m_paused = 1'b0; m_clks_since_step = 0; m_dir_up = 1'b1;
        end else if (long_ev) begin
            clr = 1'b1; m_clks_since_step = 0;
        end else if (short_ev) begin
            if (!is_auto) en = 1'b1;
            else begin
                m_paused = !m_paused;
                if (!m_paused) m_clks_since_step = 0;
            end
        end else if (tick) begin
            en = 1'b1; m_clks_since_step = 0;
            if (m_mode == 1) up = 1'b1;
            else if (m_mode == 2) up = 1'b0;
            else if (m_dir_up && int'(count) == CMAX) begin m_dir_up = 1'b0; up = 1'b0; end
            else if (!m_dir_up && int'(count) == 0) begin m_dir_up = 1'b1; up = 1'b1; end
            else up = m_dir_up;
        end else if (is_auto && !m_paused) m_clks_since_step++;
        else if (!is_auto) m_clks_since_step = 0;
        s.tag = edge_cnt + 1; s.mode = m_mode; s.paused = m_paused; st_q.push_back(s);
        if (en || clr) begin
            e.tag = edge_cnt + 1; e.clr = clr; e.up = up; ev_q.push_back(e);
            if (clr) m_cnt = 0;
            else m_cnt = (m_cnt + (up ? 1 : CMAX)) % (CMAX + 1);
        end
    endtask

    task automatic cyc();
        if (reset) count = '0;
        else if (rand_count) count = N'($urandom_range(0, CMAX));
        else count = N'(m_cnt);
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic hold_step(input int n);
        step_btn = 1'b1; idle(n); step_btn = 1'b0; cyc();
    endtask

    task automatic tap_mode();
        mode_btn = 1'b1; cyc(); mode_btn = 1'b0; cyc();
    endtask

    // Monitor: compare every clock's status and every strobe against the queues.
    initial begin
        ev_t e; st_t s;
        forever begin
            @(negedge clock);
            while (st_q.size() > 0 && st_q[0].tag < edge_cnt) void'(st_q.pop_front());
            if (st_q.size() > 0 && st_q[0].tag == edge_cnt) begin
                s = st_q.pop_front();
                n_cmp++;
                if (int'(mode) != s.mode || paused !== s.paused) begin
                    n_bad++;
                    $display("FAIL status @%0d: mode=%0d paused=%0b, expected mode=%0d paused=%0b",
                             edge_cnt, mode, paused, s.mode, s.paused);
                end
            end
            while (ev_q.size() > 0 && ev_q[0].tag < edge_cnt) begin
                e = ev_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL missed_strobe @%0d: no pulse, expected clr=%0b up=%0b", e.tag, e.clr, e.up);
            end
            if (cnt_en === 1'b1 || cnt_clear === 1'b1) begin
                n_cmp++;
                if (ev_q.size() > 0 && ev_q[0].tag == edge_cnt) begin
                    e = ev_q.pop_front();
                    if (cnt_clear !== e.clr || cnt_en !== !e.clr || (!e.clr && cnt_up !== e.up)) begin
                        n_bad++;
                        $display("FAIL strobe @%0d: en=%0b clr=%0b up=%0b, expected en=%0b clr=%0b up=%0b",
                                 edge_cnt, cnt_en, cnt_clear, cnt_up, !e.clr, e.clr, e.up);
                    end
                end else begin
                    n_bad++;
                    $display("FAIL spurious_strobe @%0d: en=%0b clr=%0b, expected none", edge_cnt, cnt_en, cnt_clear);
                end
            end
        end
    end

    initial begin
        int k;
        model_reset();
        reset = 1'b1; step_btn = 1'b1; mode_btn = 1'b0; count = '0;
        idle(3);
        n_cmp++;
        if (cnt_en !== 1'b0 || cnt_clear !== 1'b0 || cnt_up !== 1'b1 || mode !== 2'b00 || paused !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: en=%0b clr=%0b up=%0b mode=%0d paused=%0b, expected 0 0 1 0 0",
                     cnt_en, cnt_clear, cnt_up, mode, paused);
        end
        reset = 1'b0; idle(2);
        step_btn = 1'b0; idle(3);

        // Manual short press, then long press
        hold_step(3); idle(3);
        hold_step(10); idle(3);

        // AUTO_UP with pause and resume
        tap_mode(); idle(12);
        hold_step(2); idle(10);
        hold_step(2); idle(10);

        // BOUNCE with the count following the predicted strobes
        tap_mode(); tap_mode(); idle(70);

        // Mode edge on the prescaler terminal cycle
        k = 0;
        while (!(m_mode != 0 && !m_paused && m_clks_since_step == TD - 1) && k < 20) begin cyc(); k++; end
        if (k >= 20) begin n_cmp++; n_bad++; $display("FAIL wait_terminal: timeout, expected terminal within 20"); end
        tap_mode(); idle(4);
        tap_mode(); idle(3);

        // Long-press threshold coincides with a mode edge
        step_btn = 1'b1; cyc();
        k = 0;
        while (m_since_press < LP - 1 && k < 20) begin cyc(); k++; end
        if (k >= 20) begin n_cmp++; n_bad++; $display("FAIL wait_hold: timeout, expected threshold within 20"); end
        mode_btn = 1'b1; cyc(); mode_btn = 1'b0; cyc();
        step_btn = 1'b0; idle(6);

        // Reset while the hold counter is at 5
        step_btn = 1'b1; cyc();
        k = 0;
        while (m_since_press < 5 && k < 20) begin cyc(); k++; end
        reset = 1'b1; idle(2);
        reset = 1'b0; idle(4);
        step_btn = 1'b0; idle(4);

        // Randomised traffic
        for (int it = 0; it < 500; it++) begin
            case ($urandom_range(0, 9))
                0, 1: tap_mode();
                2, 3, 4: hold_step($urandom_range(1, 12));
                5: idle($urandom_range(1, 12));
                6: rand_count = ($urandom_range(0, 2) == 0);
                7, 8: begin
                    for (int j = 0; j < $urandom_range(3, 15); j++) begin
                        step_btn = 1'($urandom_range(0, 1));
                        mode_btn = ($urandom_range(0, 3) == 0);
                        cyc();
                    end
                    step_btn = 1'b0; mode_btn = 1'b0; cyc();
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        reset = 1'b1; idle($urandom_range(1, 3)); reset = 1'b0;
                    end
                    cyc();
                end
            endcase
        end

        step_btn = 1'b0; mode_btn = 1'b0; idle(4);
        @(negedge clock); #1;
        n_cmp++;
        if (ev_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d strobes outstanding, expected 0", ev_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
